// File: rtl/psk_pkg.sv
// Shared constants for the PSK signal formatter: stream select codes,
// alignment modes and the saturation counter width.
package psk_pkg;

  localparam logic [1:0] SEL_I    = 2'd0;
  localparam logic [1:0] SEL_Q    = 2'd1;
  localparam logic [1:0] SEL_SUM  = 2'd2;
  localparam logic [1:0] SEL_DIFF = 2'd3;

  localparam logic ALIGN_RIGHT = 1'b0;
  localparam logic ALIGN_MSB   = 1'b1;

  localparam int SAT_CNT_W = 16;

endpackage

// File: rtl/psk_sat_shift.sv
// Combinational signed left shift with saturation to OUT_W bits.
// The intermediate is wide enough that the largest shift can never overflow it.
module psk_sat_shift #(
  parameter int IN_W    = 13,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 4
) (
  input  logic signed [IN_W-1:0]    din,
  input  logic        [SHIFT_W-1:0] shift,
  output logic        [OUT_W-1:0]   value,
  output logic                      sat
);

  localparam int EXT_W = OUT_W + (2 ** SHIFT_W) - 1;

  logic [EXT_W-1:0]     ext;
  logic [EXT_W-1:0]     shifted;
  logic [EXT_W-OUT_W:0] hi;
  logic                 fits;

  always_comb begin
    ext     = {{(EXT_W - IN_W){din[IN_W-1]}}, din};
    shifted = ext << shift;
    // In range only if every bit from the output sign bit upward agrees.
    hi      = shifted[EXT_W-1:OUT_W-1];
    fits    = (&hi) | ~(|hi);
    sat     = ~fits;
    if (fits) begin
      value = shifted[OUT_W-1:0];
    end else if (shifted[EXT_W-1]) begin
      value = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      value = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/psk_signal_formatter.sv
// Two-stage valid/ready formatter: stage 1 combines I/Q and decimates,
// stage 2 aligns/scales/saturates; counts emitted saturated samples.
module psk_signal_formatter
  import psk_pkg::*;
#(
  parameter int I_WIDTH = 12,
  parameter int O_WIDTH = 16,
  parameter int DECIM_W = 8,
  parameter int SHIFT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [I_WIDTH-1:0]  DAC_I,
  input  logic signed [I_WIDTH-1:0]  DAC_Q,
  input  logic        [1:0]          sel,
  input  logic                       align,
  input  logic        [SHIFT_W-1:0]  shift,
  input  logic        [DECIM_W-1:0]  decim,
  input  logic                       clr_sat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [O_WIDTH-1:0]  PSK_signal,
  output logic                       sat_flag,
  output logic        [SAT_CNT_W-1:0] sat_cnt
);

  // Handshake: a beat moves on a port when its valid and ready are both high
  // on a rising edge; a stage advances when it is empty or its successor
  // advances, so in_ready depends combinationally on out_ready.

  localparam int V_W       = I_WIDTH + 1;
  localparam int V_LSH     = O_WIDTH - V_W;
  localparam int C_LSH     = O_WIDTH - I_WIDTH;
  localparam logic [SAT_CNT_W-1:0] SAT_MAX = '1;

  logic adv1, adv2, accept, keep;
  logic [DECIM_W-1:0] dcnt;

  logic signed [V_W-1:0] i_ext, q_ext, v;
  logic combined;

  logic                  s1_valid;
  logic signed [V_W-1:0] s1_v;
  logic                  s1_comb;
  logic                  s1_align;
  logic [SHIFT_W-1:0]    s1_shift;

  logic [O_WIDTH-1:0] sh_value, msb_value, fmt_value;
  logic               sh_sat, fmt_sat;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;
  assign accept   = in_valid && adv1;
  assign keep     = (dcnt == '0);

  always_comb begin
    i_ext    = {DAC_I[I_WIDTH-1], DAC_I};
    q_ext    = {DAC_Q[I_WIDTH-1], DAC_Q};
    combined = (sel == SEL_SUM) || (sel == SEL_DIFF);
    v        = i_ext;
    case (sel)
      SEL_I:    v = i_ext;
      SEL_Q:    v = q_ext;
      SEL_SUM:  v = i_ext + q_ext;
      SEL_DIFF: v = i_ext - q_ext;
      default:  v = i_ext;
    endcase
  end

  psk_sat_shift #(
    .IN_W    (V_W),
    .OUT_W   (O_WIDTH),
    .SHIFT_W (SHIFT_W)
  ) u_sat_shift (
    .din   (s1_v),
    .shift (s1_shift),
    .value (sh_value),
    .sat   (sh_sat)
  );

  // Widening then shifting pushes the sign-extension bits out the top,
  // leaving the chosen field in the MSBs with zero LSBs.
  always_comb begin
    if (s1_comb) begin
      msb_value = O_WIDTH'(s1_v) << V_LSH;
    end else begin
      msb_value = O_WIDTH'(s1_v[I_WIDTH-1:0]) << C_LSH;
    end
    if (s1_align == ALIGN_MSB) begin
      fmt_value = msb_value;
      fmt_sat   = 1'b0;
    end else begin
      fmt_value = sh_value;
      fmt_sat   = sh_sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt       <= '0;
      s1_valid   <= 1'b0;
      s1_v       <= '0;
      s1_comb    <= 1'b0;
      s1_align   <= ALIGN_RIGHT;
      s1_shift   <= '0;
      out_valid  <= 1'b0;
      PSK_signal <= '0;
      sat_flag   <= 1'b0;
      sat_cnt    <= '0;
    end else begin
      // Lowering decim below dcnt wraps to zero on the next accept.
      if (accept) begin
        dcnt <= (dcnt >= decim) ? '0 : dcnt + DECIM_W'(1);
      end
      if (adv1) begin
        s1_valid <= accept && keep;
        if (accept && keep) begin
          s1_v     <= v;
          s1_comb  <= combined;
          s1_align <= align;
          s1_shift <= shift;
        end
      end
      if (adv2) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          PSK_signal <= fmt_value;
          sat_flag   <= fmt_sat;
        end
      end
      if (clr_sat) begin
        sat_cnt <= '0;
      end else if (out_valid && out_ready && sat_flag && (sat_cnt != SAT_MAX)) begin
        sat_cnt <= sat_cnt + SAT_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_psk_signal_formatter.sv
// Directed bench for psk_signal_formatter: hand-computed vectors feed an
// expected queue that a negedge monitor checks on every output transfer.
module tb_psk_signal_formatter;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] DAC_I;
  logic [11:0] DAC_Q;
  logic [1:0]  sel;
  logic        align;
  logic [3:0]  shift;
  logic [7:0]  decim;
  logic        clr_sat;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] PSK_signal;
  logic        sat_flag;
  logic [15:0] sat_cnt;

  logic [16:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  psk_signal_formatter dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .DAC_I      (DAC_I),
    .DAC_Q      (DAC_Q),
    .sel        (sel),
    .align      (align),
    .shift      (shift),
    .decim      (decim),
    .clr_sat    (clr_sat),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .PSK_signal (PSK_signal),
    .sat_flag   (sat_flag),
    .sat_cnt    (sat_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: each output transfer must match the head of exp_q
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_qsize", exp_q.size(), 1);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("out_data", PSK_signal, e[15:0]);
        check("out_sat", sat_flag, e[16]);
      end
    end
  end

  // driver: present one sample and hold until accepted
  task automatic send(input logic [11:0] i, input logic [11:0] q, input logic [1:0] s,
                      input logic a, input logic [3:0] sh, input logic [7:0] d,
                      input logic kept, input logic [16:0] e);
    logic ok;
    DAC_I = i; DAC_Q = q; sel = s; align = a; shift = sh; decim = d;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout", in_ready, 1);
    else if (kept) exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    in_valid = 1'b0;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    check(tag, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic r;
    rst = 1'b1; in_valid = 1'b0; DAC_I = '0; DAC_Q = '0; sel = 2'd0;
    align = 1'b0; shift = '0; decim = '0; clr_sat = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_psk", PSK_signal, 16'h0000);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // latency: -5 right-aligned, no gain
    send(12'hFFB, 12'h000, 2'd0, 1'b0, 4'd0, 8'd0, 1'b1, {1'b0, 16'hFFFB});
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_one_cycle", out_valid, 0);
    @(negedge clk);
    check("lat_two_cycle", out_valid, 1);
    check("lat_data", PSK_signal, 16'hFFFB);
    drain("drain_latency");

    // gain boundary: 0x7FF<<4 fits, <<5 saturates
    send(12'h7FF, 12'h000, 2'd0, 1'b0, 4'd4, 8'd0, 1'b1, {1'b0, 16'h7FF0});
    send(12'h7FF, 12'h000, 2'd0, 1'b0, 4'd5, 8'd0, 1'b1, {1'b1, 16'h7FFF});
    drain("drain_gain");
    check("sat_cnt_after_gain", sat_cnt, 1);

    // combining and alignment
    send(12'h7FF, 12'h7FF, 2'd2, 1'b1, 4'd0,  8'd0, 1'b1, {1'b0, 16'h7FF0});
    send(12'h800, 12'h7FF, 2'd3, 1'b0, 4'd0,  8'd0, 1'b1, {1'b0, 16'hF001});
    send(12'h000, 12'h801, 2'd1, 1'b1, 4'd0,  8'd0, 1'b1, {1'b0, 16'h8010});
    send(12'h123, 12'h000, 2'd0, 1'b1, 4'd7,  8'd0, 1'b1, {1'b0, 16'h1230});
    send(12'h001, 12'h000, 2'd3, 1'b0, 4'd15, 8'd0, 1'b1, {1'b1, 16'h7FFF});
    send(12'hFFB, 12'h000, 2'd0, 1'b0, 4'd15, 8'd0, 1'b1, {1'b1, 16'h8000});
    send(12'h7FF, 12'h7FF, 2'd2, 1'b0, 4'd3,  8'd0, 1'b1, {1'b0, 16'h7FF0});
    drain("drain_combine");
    check("sat_cnt_after_combine", sat_cnt, 3);

    // decim=2: of 1..9 keep 1, 4, 7
    for (int k = 1; k <= 9; k++) begin
      send(12'(k), 12'h000, 2'd0, 1'b0, 4'd0, 8'd2, (k == 1 || k == 4 || k == 7),
           {1'b0, 16'(k)});
    end
    drain("drain_decim");

    // decim 5 leaves dcnt=4; dropping to 1 wraps, next accept kept
    send(12'd20, 12'h000, 2'd0, 1'b0, 4'd0, 8'd5, 1'b1, {1'b0, 16'd20});
    send(12'd21, 12'h000, 2'd0, 1'b0, 4'd0, 8'd5, 1'b0, {1'b0, 16'd21});
    send(12'd22, 12'h000, 2'd0, 1'b0, 4'd0, 8'd5, 1'b0, {1'b0, 16'd22});
    send(12'd23, 12'h000, 2'd0, 1'b0, 4'd0, 8'd5, 1'b0, {1'b0, 16'd23});
    send(12'd24, 12'h000, 2'd0, 1'b0, 4'd0, 8'd1, 1'b0, {1'b0, 16'd24});
    send(12'd25, 12'h000, 2'd0, 1'b0, 4'd0, 8'd1, 1'b1, {1'b0, 16'd25});
    send(12'd26, 12'h000, 2'd0, 1'b0, 4'd0, 8'd1, 1'b0, {1'b0, 16'd26});
    send(12'd27, 12'h000, 2'd0, 1'b0, 4'd0, 8'd1, 1'b1, {1'b0, 16'd27});
    send(12'd28, 12'h000, 2'd0, 1'b0, 4'd0, 8'd1, 1'b0, {1'b0, 16'd28});
    drain("drain_wrap");

    // backpressure: 2 samples buffered, output held stable
    out_ready = 1'b0;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      DAC_I = 12'(40 + n); DAC_Q = '0; sel = 2'd0; align = 1'b0; shift = '0; decim = '0;
      in_valid = 1'b1;
      @(negedge clk);
      r = in_ready;
      if (c >= 2) begin
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_hold_data", PSK_signal, 16'd40);
      end
      @(posedge clk);
      #1;
      if (r) begin
        exp_q.push_back({1'b0, 16'(40 + n)});
        n++;
      end
    end
    check("bp_buffered", n, 2);
    out_ready = 1'b1;
    send(12'd42, 12'h000, 2'd0, 1'b0, 4'd0, 8'd0, 1'b1, {1'b0, 16'd42});
    send(12'd43, 12'h000, 2'd0, 1'b0, 4'd0, 8'd0, 1'b1, {1'b0, 16'd43});
    send(12'd44, 12'h000, 2'd0, 1'b0, 4'd0, 8'd0, 1'b1, {1'b0, 16'd44});
    drain("drain_bp");

    // sat_cnt clear, then clear colliding with a saturated transfer
    clr_sat = 1'b1;
    @(posedge clk);
    #1 clr_sat = 1'b0;
    check("clr_sat_cnt", sat_cnt, 0);
    for (int k = 0; k < 3; k++) begin
      send(12'h7FF, 12'h000, 2'd0, 1'b0, 4'd5, 8'd0, 1'b1, {1'b1, 16'h7FFF});
    end
    drain("drain_sat3");
    check("sat_cnt_three", sat_cnt, 3);
    out_ready = 1'b0;
    send(12'h7FF, 12'h000, 2'd0, 1'b0, 4'd5, 8'd0, 1'b1, {1'b1, 16'h7FFF});
    in_valid = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    check("sat4_out_valid", out_valid, 1);
    @(posedge clk);
    #1 out_ready = 1'b1; clr_sat = 1'b1;
    @(posedge clk);
    #1 clr_sat = 1'b0;
    @(negedge clk);
    check("clr_wins", sat_cnt, 0);
    check("clr_qsize", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // reset mid-burst
    send(12'd60, 12'h000, 2'd0, 1'b0, 4'd15, 8'd0, 1'b1, {1'b1, 16'h7FFF});
    send(12'd61, 12'h000, 2'd0, 1'b0, 4'd0,  8'd0, 1'b1, {1'b0, 16'd61});
    send(12'd62, 12'h000, 2'd0, 1'b0, 4'd0,  8'd0, 1'b1, {1'b0, 16'd62});
    send(12'd63, 12'h000, 2'd0, 1'b0, 4'd0,  8'd0, 1'b1, {1'b0, 16'd63});
    check("pre_rst_sat_cnt", sat_cnt, 1);
    rst = 1'b1; in_valid = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_psk", PSK_signal, 16'h0000);
    check("midrst_sat_cnt", sat_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_no_stale", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(12'd70, 12'h000, 2'd0, 1'b0, 4'd0, 8'd0, 1'b1, {1'b0, 16'd70});
    drain("drain_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/psk_signal_formatter.md
# psk_signal_formatter

Registered, flow-controlled formatter that converts the 12-bit baseband DAC I/Q samples of the PSK modulator into the single wide real-valued PSK stream used by the DAC interface and the loopback path. It replaces the fixed combinational extension stage with the following runtime controls:
- stream selection and I±Q combining;
- a right-aligned mode with left-shift gain and saturation, or an MSB-aligned mode;
- integer decimation.

It uses a 2-stage valid/ready pipeline and keeps a saturation event counter.

## Interface
Parameters:
- I_WIDTH, 12, width of each signed input component
- O_WIDTH, 16, output width; must satisfy O_WIDTH ≥ I_WIDTH+1
- DECIM_W, 8, width of the decimation control
- SHIFT_W, 4, width of the gain shift control

Ports (clock and reset first):
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  input can be accepted; transfer occurs when in_valid && in_ready
- DAC_I  in  I_WIDTH  signed I component
- DAC_Q  in  I_WIDTH  signed Q component
- sel  in  2  stream select: 0 = I, 1 = Q, 2 = I+Q, 3 = I−Q
- align  in  1  0 = right-aligned sign-extended with gain, 1 = MSB-aligned with zero LSBs
- shift  in  SHIFT_W  left-shift gain, applied only when align=0
- decim  in  DECIM_W  keep 1 of every decim+1 accepted samples; 0 = pass all
- clr_sat  in  1  synchronous clear of sat_cnt
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream ready; transfer occurs when out_valid && out_ready
- PSK_signal  out  O_WIDTH  signed formatted sample
- sat_flag  out  1  current PSK_signal was saturated; qualified by out_valid
- sat_cnt  out  16  saturating count of emitted saturated samples

## Operation
Stage 1 (combine and decimate):
- Acts on each accepted input. sel, align, shift and decim are sampled at acceptance and travel with that sample.
- Computes v as an (I_WIDTH+1)-bit signed value: sel 0/1 gives the component sign-extended by 1 bit; sel 2/3 gives the exact sum or difference (no truncation).
- Decimation counter dcnt, DECIM_W bits:
  - On each accept, the sample is kept iff dcnt==0.
  - dcnt then becomes 0 if dcnt ≥ decim, else dcnt+1.
  - Lowering decim mid-stream therefore wraps cleanly.
  - Dropped samples complete the input handshake but never set the stage-1 valid bit.

Stage 2 (format):
- align=0: sign-extend v to O_WIDTH+15 bits, shift left by shift, and saturate to [−2^(O_WIDTH−1), 2^(O_WIDTH−1)−1]. sat_flag=1 iff clipping occurred.
- align=1:
  - sel 0/1: the I_WIDTH-bit component is placed in the MSBs with zero LSBs.
  - sel 2/3: v is placed in the MSBs with zero LSBs.
  - shift is ignored and sat_flag=0.

Flow control:
- adv2 = !out_valid || out_ready
- adv1 = !s1_valid || adv2
- in_ready = adv1. This is a combinational path from out_ready.
- Output data is held stable while out_valid && !out_ready.

sat_cnt:
- Increments on each output transfer with sat_flag=1 and sticks at 0xFFFF.
- clr_sat zeroes it. On a simultaneous clr_sat and increment, clear wins (result 0).

## Timing
- Latency: an accepted, kept sample appears on out_valid 2 cycles after acceptance when out_ready stays high.
- Throughput: 1 sample per cycle with decim=0 and no backpressure.
- Reset values: out_valid=0, PSK_signal=0, sat_flag=0, sat_cnt=0, dcnt=0, s1_valid=0. in_ready=1 once rst deasserts.
- Reset mid-operation: all in-flight samples are discarded and nothing is emitted afterward until new samples are accepted.
- Control changes affect only samples accepted after the change, never samples already in the pipeline.

## Structure
- Shared package psk_pkg holds the SEL_I, SEL_Q, SEL_SUM and SEL_DIFF constants, the ALIGN_RIGHT and ALIGN_MSB constants, and the sat_cnt width constant (16).
- One sub-module: psk_sat_shift (combinational left shift plus saturation; parameters IN_W, OUT_W, SHIFT_W; outputs value and sat), instantiated in stage 2.
- Pipeline registers, decimation and the counter live in the top module.

## Test plan
- Reset, then sel=0, align=0, shift=0, DAC_I=−5 → PSK_signal=16'hFFFB 2 cycles after accept; sat_flag=0.
- align=0, shift=4, DAC_I=12'h7FF → 0x7FF<<4 = 0x7FF0 fits, sat_flag=0. Then shift=5 → 0x7FFF with sat_flag=1, sat_cnt=1.
- sel=2, DAC_I=DAC_Q=12'h7FF, align=1 → v=13'h0FFE, PSK_signal=16'h7FF0. sel=3, DAC_I=−2048, DAC_Q=2047 → v=−4095 (13'h1001), align=0 gives 16'hF001.
- decim=2, 9 accepted samples 1..9 → outputs 1, 4, 7 only. Changing decim from 5 to 1 when dcnt=4 → next accept kept after the wrap.
- out_ready held low for 5 cycles with continuous in_valid → at most 2 samples buffered, in_ready=0, PSK_signal stable. On release, no loss or duplication and order is preserved.
- Saturate 3 outputs, assert clr_sat in the same cycle as the 4th saturated transfer → sat_cnt=0. Assert rst mid-burst → out_valid=0 immediately and no stale sample emitted afterward.
